// File: rtl/dir_cmd_scheduler_pkg.sv
// Direction codes, scheduler FSM encoding and key-arbitration helper for dir_cmd_scheduler.
// Build option DIR_SCHED_STATS_EN (see top) adds the drop_cnt statistics output.
`ifndef DIR_CMD_SCHEDULER_DEFINES
`define DIR_CMD_SCHEDULER_DEFINES
`define TOP_DIR   2'd0
`define DOWN_DIR  2'd1
`define LEFT_DIR  2'd2
`define RIGHT_DIR 2'd3
`endif

package dir_cmd_scheduler_pkg;

  typedef logic [1:0] dir_t;

  typedef enum logic [1:0] {
    ST_WAIT_START = 2'd0,
    ST_RUN        = 2'd1,
    ST_PAUSED     = 2'd2,
    ST_STOPPED    = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic vld;
    dir_t dir;
  } key_sel_t;

  // Codes are paired so that flipping bit 0 gives the reverse heading.
  function automatic dir_t dir_opposite(input dir_t d);
    return d ^ 2'd1;
  endfunction

  // keys = {up, down, left, right}; highest priority wins.
  function automatic key_sel_t key_pick(input logic [3:0] keys);
    key_sel_t s;
    s.vld = |keys;
    if (keys[3])      s.dir = `TOP_DIR;
    else if (keys[2]) s.dir = `DOWN_DIR;
    else if (keys[1]) s.dir = `LEFT_DIR;
    else              s.dir = `RIGHT_DIR;
    return s;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO for direction codes; flush wins over push/pop, zero-latency head/tail.
// A push while full succeeds only if a pop shares the cycle, recycling the freed slot.
module dir_fifo #(
  parameter int QDEPTH = 2,
  parameter int W      = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head,
  output logic [W-1:0] o_tail
);
  localparam int AW = $clog2(QDEPTH);

  logic [W-1:0]  r_mem [QDEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] w_last_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (AW+1)'(QDEPTH));
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign w_last_ptr = r_wr_ptr - AW'(1);
  assign o_head     = r_mem[r_rd_ptr];
  assign o_tail     = r_mem[w_last_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/dir_cmd_scheduler.sv
// Queues debounced direction presses (reversal/duplicate filtered) and releases one per move tick.
// Optional macro DIR_SCHED_STATS_EN adds a saturating drop_cnt output.
module dir_cmd_scheduler
  import dir_cmd_scheduler_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int QDEPTH   = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       pause_req,
  input  logic       game_over,
  input  logic       restart,
  output logic [1:0] direction,
  output logic       move_tick,
  output logic       running
`ifdef DIR_SCHED_STATS_EN
  ,
  output logic [7:0] drop_cnt
`endif
);
  localparam int CW = $clog2(TICK_DIV);

  sched_state_t  r_state;
  sched_state_t  w_state_nxt;
  logic [CW-1:0] r_cnt;
  dir_t          r_dir;
  logic          r_tick;

  key_sel_t w_key;
  dir_t     w_tail;
  dir_t     w_head;
  dir_t     w_fifo_tail;
  logic     w_full;
  logic     w_empty;
  logic     w_term;
  logic     w_count_en;
  logic     w_tick_nxt;
  logic     w_pop;
  logic     w_enq_try;
  logic     w_reject;
  logic     w_push;

  assign w_key = key_pick({key_up, key_down, key_left, key_right});

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_WAIT_START;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (restart) begin
      w_state_nxt = ST_WAIT_START;
    end else begin
      case (r_state)
        ST_WAIT_START: if (w_key.vld) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (game_over)      w_state_nxt = ST_STOPPED;
          else if (pause_req) w_state_nxt = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (game_over)      w_state_nxt = ST_STOPPED;
          else if (pause_req) w_state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    running   = (r_state == ST_RUN);
    direction = r_dir;
    move_tick = r_tick;
  end

  // The counter only advances on cycles that stay in RUN, so a pause freezes it mid-period.
  assign w_term     = (r_cnt == CW'(TICK_DIV - 1));
  assign w_count_en = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
  assign w_tick_nxt = w_count_en && w_term;
  assign w_pop      = w_tick_nxt && !w_empty;

  assign w_tail    = w_empty ? r_dir : w_fifo_tail;
  assign w_enq_try = (r_state == ST_RUN) && w_key.vld && !restart;
  assign w_reject  = (w_key.dir == w_tail) || (w_key.dir == dir_opposite(w_tail));
  assign w_push    = w_enq_try && !w_reject;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt  <= '0;
      r_dir  <= `TOP_DIR;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick_nxt;
      if (restart || r_state == ST_WAIT_START) r_cnt <= '0;
      else if (w_count_en)                     r_cnt <= w_term ? '0 : r_cnt + CW'(1);
      if (restart)                                 r_dir <= `TOP_DIR;
      else if (r_state == ST_WAIT_START && w_key.vld) r_dir <= w_key.dir;
      else if (w_pop)                              r_dir <= w_head;
    end
  end

  dir_fifo #(
    .QDEPTH (QDEPTH),
    .W      (2)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_flush (restart),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (w_key.dir),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_tail  (w_fifo_tail)
  );

`ifdef DIR_SCHED_STATS_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop   = w_enq_try && (w_reject || (w_full && !w_pop));
  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                        r_drop_cnt <= '0;
    else if (restart)                      r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_dir_cmd_scheduler.sv
// Self-checking bench for dir_cmd_scheduler: directed vector table, hand sequences, random vs model.
module tb_dir_cmd_scheduler;
  localparam int TD = 4;
  localparam int QD = 2;
  localparam logic [3:0] K_0 = 4'b0000, K_U = 4'b1000, K_D = 4'b0100, K_L = 4'b0010, K_R = 4'b0001;
  localparam int S_WAIT = 0, S_RUN = 1, S_PAUSE = 2, S_STOP = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] keys = 4'b0;
  logic       pause_req = 1'b0, game_over = 1'b0, restart = 1'b0;
  logic [1:0] direction;
  logic       move_tick, running;
`ifdef DIR_SCHED_STATS_EN
  logic [7:0] drop_cnt;
`endif

  always #5 sys_clk = ~sys_clk;

  dir_cmd_scheduler #(.TICK_DIV(TD), .QDEPTH(QD)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_up    (keys[3]),
    .key_down  (keys[2]),
    .key_left  (keys[1]),
    .key_right (keys[0]),
    .pause_req (pause_req),
    .game_over (game_over),
    .restart   (restart),
    .direction (direction),
    .move_tick (move_tick),
    .running   (running)
`ifdef DIR_SCHED_STATS_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] k;
    logic       rs;
    int         dir;
    int         tick;
    int         run;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [3:0] k, input logic rs, input int d, input int t, input int r);
    vec_t v;
    v.k = k; v.rs = rs; v.dir = d; v.tick = t; v.run = r;
    vecs.push_back(v);
  endfunction

  function automatic void idles(input int n, input int d);
    for (int i = 0; i < n; i++) add(K_0, 1'b0, d, 0, 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic [3:0] k, input logic p, input logic g, input logic r);
    keys = k; pause_req = p; game_over = g; restart = r;
    @(negedge sys_clk);
  endtask

  // Reference model: state after each rising edge, expressed as a queue of pending headings.
  int m_state, m_dir, m_cnt, m_tick, m_drop;
  int m_q[$];

  function automatic void model_reset();
    m_state = S_WAIT; m_dir = 0; m_cnt = 0; m_tick = 0; m_drop = 0;
    m_q.delete();
  endfunction

  function automatic void model_step(input logic [3:0] k, input logic p, input logic g, input logic r);
    int cand, tail;
    bit tick_now;
    cand = -1;
    for (int c = 0; c < 4; c++) if (cand < 0 && k[3-c]) cand = c;
    m_tick = 0;
    if (r) begin
      model_reset();
      return;
    end
    case (m_state)
      S_WAIT: if (cand >= 0) begin m_dir = cand; m_state = S_RUN; m_cnt = 0; end
      S_RUN: begin
        tail = (m_q.size() > 0) ? m_q[$] : m_dir;
        tick_now = 0;
        if (g) m_state = S_STOP;
        else if (p) m_state = S_PAUSE;
        else begin
          m_cnt++;
          if (m_cnt == TD) begin m_cnt = 0; tick_now = 1; end
        end
        if (tick_now && m_q.size() > 0) m_dir = m_q.pop_front();
        if (cand >= 0) begin
          if (cand == tail || cand == (tail ^ 1)) m_drop++;
          else if (m_q.size() >= QD) m_drop++;
          else m_q.push_back(cand);
        end
        if (m_drop > 255) m_drop = 255;
        m_tick = tick_now;
      end
      S_PAUSE: begin
        if (g) m_state = S_STOP;
        else if (p) m_state = S_RUN;
      end
      default: ;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    bit go_lvl;
    logic [3:0] rk;
    logic rp, rr;

    // Start, 4-cycle tick period
    add(K_L, 0, 2, 0, 1); idles(3, 2); add(K_0, 0, 2, 1, 1);
    idles(3, 2); add(K_0, 0, 2, 1, 1);
    // Restart, start UP, reversal DOWN rejected, empty-queue tick
    add(K_0, 1, 0, 0, 0);
    add(K_U, 0, 0, 0, 1); add(K_D, 0, 0, 0, 1); idles(2, 0); add(K_0, 0, 0, 1, 1);
    // LEFT then DOWN two cycles apart
    add(K_L, 0, 0, 0, 1); idles(1, 0); add(K_D, 0, 0, 0, 1); add(K_0, 0, 2, 1, 1);
    idles(3, 2); add(K_0, 0, 1, 1, 1);
    // Overflow: LEFT, DOWN accepted, RIGHT dropped
    add(K_L, 0, 1, 0, 1); add(K_D, 0, 1, 0, 1); add(K_R, 0, 1, 0, 1); add(K_0, 0, 2, 1, 1);
    idles(3, 2); add(K_0, 0, 1, 1, 1);
    idles(3, 1); add(K_0, 0, 1, 1, 1);
    // Full queue with push on the terminal-count cycle
    add(K_L, 0, 1, 0, 1); add(K_U, 0, 1, 0, 1); idles(1, 1); add(K_R, 0, 2, 1, 1);
    idles(3, 2); add(K_0, 0, 0, 1, 1);
    idles(3, 0); add(K_0, 0, 3, 1, 1);
    idles(3, 3); add(K_0, 0, 3, 1, 1);

    repeat (2) @(negedge sys_clk);
    chk("reset_dir", direction, 0);
    chk("reset_tick", move_tick, 0);
    chk("reset_run", running, 0);
`ifdef DIR_SCHED_STATS_EN
    chk("reset_drop", drop_cnt, 0);
`endif
    sys_rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].k, 1'b0, 1'b0, vecs[i].rs);
      chk($sformatf("row%0d_dir", i), direction, vecs[i].dir);
      chk($sformatf("row%0d_tick", i), move_tick, vecs[i].tick);
      chk($sformatf("row%0d_run", i), running, vecs[i].run);
    end
`ifdef DIR_SCHED_STATS_EN
    chk("table_drop", drop_cnt, 2);
`endif

    // Pause at count 2, keys ignored while paused, resume, then game over and restart
    step(K_0, 0, 0, 1);
    step(K_U, 0, 0, 0);
    step(K_0, 0, 0, 0);
    step(K_0, 0, 0, 0);
    step(K_0, 1, 0, 0);
    chk("pause_run", running, 0);
    for (int i = 0; i < 10; i++) begin
      step((i == 3) ? K_L : K_0, 0, 0, 0);
      chk($sformatf("paused%0d_tick", i), move_tick, 0);
    end
    step(K_0, 1, 0, 0);
    chk("resume_run", running, 1);
    chk("resume_tick", move_tick, 0);
    step(K_0, 0, 0, 0);
    chk("resume1_tick", move_tick, 0);
    step(K_0, 0, 0, 0);
    chk("resume2_tick", move_tick, 1);
    chk("resume2_dir", direction, 0);
    step(K_0, 0, 1, 0);
    chk("over_run", running, 0);
    for (int i = 0; i < 8; i++) begin
      step((i == 2) ? K_R : K_0, (i == 4), 1, 0);
      chk($sformatf("over%0d_tick", i), move_tick, 0);
      chk($sformatf("over%0d_run", i), running, 0);
    end
    step(K_0, 0, 1, 1);
    chk("restart_dir", direction, 0);
    chk("restart_run", running, 0);
    chk("restart_tick", move_tick, 0);

    // Asynchronous reset while move_tick is high
    step(K_R, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(K_0, 0, 0, 0);
      if (move_tick) found = 1;
    end
    chk("midtick_seen", found, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("midtick_tick", move_tick, 0);
    chk("midtick_dir", direction, 0);
    chk("midtick_run", running, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Random stimulus against the model
    model_reset();
    go_lvl = 0;
    for (int n = 0; n < 3000; n++) begin
      rk = K_0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) rk[b] = 1'b1;
      rp = ($urandom_range(0, 24) == 0);
      rr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 79) == 0) go_lvl = ~go_lvl;
      step(rk, rp, go_lvl, rr);
      model_step(rk, rp, go_lvl, rr);
      chk($sformatf("rnd%0d_dir", n), direction, m_dir);
      chk($sformatf("rnd%0d_tick", n), move_tick, m_tick);
      chk($sformatf("rnd%0d_run", n), running, (m_state == S_RUN));
`ifdef DIR_SCHED_STATS_EN
      chk($sformatf("rnd%0d_drop", n), drop_cnt, m_drop);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
